// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with double-buffered frames; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: a/num/seg/frame_start are registered and move together on each slot tick; backpressure: load_ready low while pending is full.
module seg_scan_ctrl #(
  parameter int DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] digits_in,
  input  logic [2:0]  num_in,
  output logic [2:0]  a,
  output logic [2:0]  num,
  output logic [6:0]  seg,
  output logic        frame_start
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [PW-1:0] presc;
  logic          tick;

  logic          pend_full;
  logic [15:0]   pend_dig;
  logic [2:0]    pend_num;
  logic [15:0]   act_dig;
  logic [2:0]    act_num;

  logic [2:0]    a_nxt;
  logic          frame_end;
  logic [15:0]   act_dig_nxt;
  logic [2:0]    act_num_nxt;
  logic [6:0]    seg_nxt;
  logic [3:0]    digit_nxt;
  logic          load_fire;
  logic [2:0]    num_in_legal;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i is a leading zero when it and every active digit above it are zero.
  function automatic logic lead_zero(input logic [15:0] d, input logic [2:0] n, input logic [2:0] i);
    logic blank;
    blank = (i != 3'd0);
    for (int j = 0; j < 4; j++) begin
      if ((3'(j) >= i) && (3'(j) < n) && (d[j*4 +: 4] != 4'd0)) begin
        blank = 1'b0;
      end
    end
    return blank;
  endfunction
`endif

  assign tick       = (presc == PMAX);
  assign load_ready = !pend_full;
  assign load_fire  = load_valid && !pend_full;
  assign num        = act_num;

  always_comb begin
    num_in_legal = 3'd0;
    case (num_in)
      3'd3:    num_in_legal = 3'd3;
      3'd4:    num_in_legal = 3'd4;
      default: num_in_legal = 3'd0;
    endcase
  end

  // An empty frame parks the scan on index 0, so every tick ends a frame.
  always_comb begin
    a_nxt = a;
    if (tick) begin
      if ((act_num == 3'd0) || (a == act_num - 3'd1)) begin
        a_nxt = 3'd0;
      end else begin
        a_nxt = a + 3'd1;
      end
    end
  end

  assign frame_end = tick && (a_nxt == 3'd0);

  always_comb begin
    act_dig_nxt = act_dig;
    act_num_nxt = act_num;
    if (frame_end && pend_full) begin
      act_dig_nxt = pend_dig;
      act_num_nxt = pend_num;
    end
  end

  // Segments are derived from next-state values so they land on the same edge as a and num.
  always_comb begin
    digit_nxt = act_dig_nxt[{a_nxt[1:0], 2'b00} +: 4];
    seg_nxt   = SEG_BLANK;
    if (act_num_nxt != 3'd0) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (!lead_zero(act_dig_nxt, act_num_nxt, a_nxt)) begin
        seg_nxt = bcd_to_seg(digit_nxt);
      end
`else
      seg_nxt = bcd_to_seg(digit_nxt);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Copy and capture are exclusive: copy needs full set, capture needs it clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_dig  <= '0;
      pend_num  <= '0;
    end else if (frame_end && pend_full) begin
      pend_full <= 1'b0;
    end else if (load_fire) begin
      pend_full <= 1'b1;
      pend_dig  <= digits_in;
      pend_num  <= num_in_legal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_dig     <= '0;
      act_num     <= '0;
      a           <= '0;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      act_dig     <= act_dig_nxt;
      act_num     <= act_num_nxt;
      a           <= a_nxt;
      seg         <= seg_nxt;
      frame_start <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: random and directed loads against a slot-level display model, checked by a scoreboard monitor.
module tb_seg_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] digits_in = '0;
  logic [2:0]  num_in = '0;
  logic        load_ready;
  logic [2:0]  a;
  logic [2:0]  num;
  logic [6:0]  seg;
  logic        frame_start;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] num;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t q[$];

  // Reference model: frame contents as whole values, scan index as a counter modulo the digit count.
  bit          m_full;
  logic [15:0] m_pend_d;
  logic [15:0] m_act_d;
  int          m_pend_n;
  int          m_act_n;
  int          m_idx;
  int          m_e;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .digits_in   (digits_in),
    .num_in      (num_in),
    .a           (a),
    .num         (num),
    .seg         (seg),
    .frame_start (frame_start)
  );

  function automatic int legal_num(input logic [2:0] n);
    return (n == 3'd0 || n == 3'd3 || n == 3'd4) ? int'(n) : 0;
  endfunction

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int nib(input logic [15:0] d, input int i);
    return int'((d >> (4 * i)) & 16'hF);
  endfunction

  function automatic logic [6:0] model_seg(input logic [15:0] d, input int n, input int i);
    if (n == 0) return 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    if (i >= 1) begin
      bit allz;
      allz = 1'b1;
      for (int j = i; j < n; j++) if (nib(d, j) != 0) allz = 1'b0;
      if (allz) return 7'h7F;
    end
`endif
    return glyph(nib(d, i));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_full = 1'b0;
    m_pend_d = '0;
    m_act_d = '0;
    m_pend_n = 0;
    m_act_n = 0;
    m_idx = 0;
    m_e = 0;
    q.delete();
  endtask

  // One clock: entered and left at a falling edge.
  task automatic step(input bit v, input logic [15:0] d, input logic [2:0] n);
    bit   cap;
    bit   fe;
    int   nxt;
    exp_t e;
    load_valid = v;
    digits_in  = d;
    num_in     = n;
    #1 check("load_ready", load_ready, !m_full);
    @(posedge clk);
    cap = v && !m_full;
    m_e++;
    if (m_e % DIV == 0) begin
      nxt = (m_act_n == 0) ? 0 : (m_idx + 1) % m_act_n;
      fe = (nxt == 0);
      m_idx = nxt;
      if (fe && m_full) begin
        m_act_d = m_pend_d;
        m_act_n = m_pend_n;
        m_full = 1'b0;
      end
      e.a   = 3'(m_idx);
      e.num = 3'(m_act_n);
      e.seg = model_seg(m_act_d, m_act_n, m_idx);
      e.fs  = fe;
      q.push_back(e);
    end
    if (cap) begin
      m_pend_d = d;
      m_pend_n = legal_num(n);
      m_full = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'($urandom), 3'($urandom));
  endtask

  task automatic load_hold(input logic [15:0] d, input logic [2:0] n);
    bit took;
    int guard;
    took = 1'b0;
    guard = 0;
    while (!took && guard < 200) begin
      took = !m_full;
      step(1'b1, d, n);
      guard++;
    end
    if (!took) begin
      total++;
      bad++;
      $display("FAIL load_hold: value %h never accepted, required acceptance", d);
    end
    load_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_a", a, 0);
    check("rst_num", num, 0);
    check("rst_seg", seg, 7'h7F);
    check("rst_fs", frame_start, 0);
    check("rst_load_ready", load_ready, 1);
    @(negedge clk);
    @(negedge clk);
    model_clear();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: the DUT presents a new slot every DIV edges after reset release.
  initial begin
    int   ecnt;
    exp_t e;
    ecnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ecnt = 0;
      end else begin
        ecnt++;
        if (ecnt % DIV == 0) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL slot: DUT slot at %0t with no expected entry, required one queued", $time);
          end else begin
            e = q.pop_front();
            check("slot_a", a, e.a);
            check("slot_num", num, e.num);
            check("slot_seg", seg, e.seg);
            check("slot_fs", frame_start, e.fs);
          end
        end else if (ecnt % DIV == 1) begin
          check("fs_width", frame_start, 0);
        end
      end
    end
  end

  initial begin
    bit          v;
    logic [15:0] d;
    logic [2:0]  n;
    int          sel;

    #1 rst_n = 1'b0;
    #1;
    check("init_a", a, 0);
    check("init_num", num, 0);
    check("init_seg", seg, 7'h7F);
    check("init_fs", frame_start, 0);
    check("init_load_ready", load_ready, 1);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    load_hold(16'h1234, 3'd4);
    idle(6 * DIV);
    load_hold(16'h0987, 3'd3);
    idle(6 * DIV);
    load_hold(16'h5678, 3'd4);
    load_hold(16'h4321, 3'd4);
    idle(10 * DIV);
    load_hold(16'h1111, 3'd5);
    idle(5 * DIV);
    load_hold(16'h0005, 3'd4);
    idle(6 * DIV);
    load_hold(16'h0030, 3'd3);
    idle(5 * DIV);
    load_hold(16'h8888, 3'd4);
    idle(6 * DIV + 2);
    reset_pulse();
    idle(3 * DIV);

    repeat (1500) begin
      v = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < 4; k++) d[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      sel = $urandom_range(0, 7);
      n = (sel < 3) ? 3'd4 : (sel < 5) ? 3'd3 : (sel < 6) ? 3'd0 : 3'($urandom);
      step(v, d, n);
    end
    load_valid = 1'b0;
    idle(2 * DIV);
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 100000: clock cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL have port clk  input  1: single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have port load_valid  input  1: new display value offered.
REQ-005 SHALL have port load_ready  output  1: pending buffer empty; value accepted when load_valid && load_ready.
REQ-006 SHALL have port digits_in  input  16: four BCD nibbles; [3:0] = digit 0 (rightmost).
REQ-007 SHALL have port num_in  input  3: active digit count, legal 0, 3, 4.
REQ-008 SHALL have port a  output  3: current scan digit index for the downstream anode decoder.
REQ-009 SHALL have port num  output  3: active digit count of the displayed frame.
REQ-010 SHALL have port seg  output  7: segments {g,f,e,d,c,b,a}, active-low, for digit a.
REQ-011 SHALL have port frame_start  output  1: one-cycle pulse when a returns to 0.

Function
REQ-012 SHALL hold two buffers: pending (digits, num, full flag) and active (digits, num).
REQ-013 SHALL capture digits_in/num_in into pending on a cycle with load_valid && load_ready and set full; load_ready = !full.
REQ-014 SHALL map num_in values other than 0, 3, 4 to 0 at capture.
REQ-015 SHALL run prescaler 0..DIV-1, wrapping; tick = (prescaler == DIV-1).
REQ-016 SHALL advance a on tick: a == active num-1 -> 0, else a+1; active num 0 forces a to 0.
REQ-017 SHALL treat every tick where the next a is 0 as frame end, including every tick while active num is 0.
REQ-018 SHALL at frame end copy pending into active and clear full, when full is set; otherwise active is unchanged.
REQ-019 SHALL on a frame-end cycle that also has load_valid with full clear capture into pending only; that value becomes active at the following frame end.
REQ-020 SHALL register a, num, seg and frame_start so that all change on the same clock edge. frame_start SHALL be high for exactly the cycle after that edge.
REQ-021 SHALL encode seg for BCD 0-9 as 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10.
REQ-022 SHALL encode nibble values 10-15 as blank (0x7F).
REQ-023 SHALL drive seg = 0x7F while active num is 0.
REQ-024 SHALL drive num equal to the active num latched at the last frame end.

Reset
REQ-025 SHALL, while rst_n is low, force: prescaler 0, a 0, num 0, seg 0x7F, frame_start 0, load_ready 1, pending and active cleared.
REQ-026 SHALL, on reset assertion mid-frame, discard pending and active contents immediately, without waiting for a clock edge.
REQ-027 SHALL begin the first prescaler count on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-029 SHALL, when LEADING_ZERO_BLANK_EN is defined, blank a digit at index i >= 1 when it and every active digit above it are zero. Digit 0 is never blanked.
REQ-030 SHALL, when LEADING_ZERO_BLANK_EN is undefined, display all active digits, including leading zeros.

Verification
REQ-031 SHALL cover: DIV=4, load 0x1234 num 4 -> a cycles 1,2,3,0 every 4 clocks after transfer; seg at a=3 is 0x79; frame_start pulses at each a=0.
REQ-032 SHALL cover: num_in=3, digits 0x0987 -> a sequence 0,1,2,0; index 3 is never driven; seg at a=0 is 0x78.
REQ-033 SHALL cover: back-to-back loads with load_valid held -> second value held off (load_ready=0) until frame end. First value displays one full frame before the second.
REQ-034 SHALL cover: num_in=5 -> num=0, seg=0x7F, a held 0, frame_start on every tick.
REQ-035 SHALL cover: rst_n pulsed low mid-frame -> seg=0x7F and a=0 with no clock edge; load_ready=1.
REQ-036 SHALL cover: LEADING_ZERO_BLANK_EN defined, load 0x0005 num 4 -> seg 0x7F at a=3,2,1 and 0x12 at a=0. When undefined -> 0x40 at a=3,2,1.
